lcd_cmd_dispatch: RTL and testbench

- Command front-end directly upstream of the LCD controller.
- Accepts 4-bit image-processing commands from a host-side producer into an internal FIFO.
- Drains the FIFO onto the controller's cmd/cmd_valid inputs, issuing a command only when the controller reports not busy.
- After issuing a Write (cmd 0), holds further commands until the controller pulses done, then signals end-of-frame to the host.

---
 rtl/lcd_cmd_dispatch.sv | 112 +++++++++++
 tb/tb_lcd_cmd_dispatch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_dispatch.sv
// Command front-end for the LCD controller: buffers host commands in a FIFO and
// issues them one at a time when the controller is idle, pausing after a Write.
module lcd_cmd_dispatch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic [AW:0]   fifo_count,
    output logic [7:0]    drop_cnt,
    output logic          seq_done
);

    localparam logic [0:0]  RUN       = 1'b0;
    localparam logic [0:0]  WAIT_DONE = 1'b1;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          seq_done_q, seq_done_d;
    logic [7:0]    drop_q, drop_d;
    logic [0:0]    state_q, state_d;

    logic          full, empty, accept, push, drop, pop;
    logic [3:0]    head;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign head       = mem_q[rptr_q];
    assign host_ready = !full;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign seq_done   = seq_done_q;
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        accept = host_valid && !full;
        push   = accept && (host_cmd < 4'd12);
        drop   = accept && (host_cmd >= 4'd12);
        // cmd_valid_q in the term forces an idle guard cycle between issues
        pop    = (state_q == RUN) && !empty && !busy && !cmd_valid_q;

        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

        cmd_d       = pop ? head : cmd_q;
        cmd_valid_d = pop;

        state_d    = state_q;
        seq_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (pop && (head == 4'd0)) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d    = RUN;
                    seq_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= host_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            drop_q      <= '0;
            state_q     <= RUN;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            seq_done_q  <= seq_done_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_dispatch.sv
// Testbench for lcd_cmd_dispatch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_lcd_cmd_dispatch;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    host_cmd = '0;
    logic          host_valid = 1'b0;
    logic          busy = 1'b0;
    logic          done = 1'b0;
    logic          host_ready;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [AW:0]   fifo_count;
    logic [7:0]    drop_cnt;
    logic          seq_done;

    lcd_cmd_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int       mq[$];
    logic [3:0] m_cmd = '0;
    bit       m_cv = 0, m_seq = 0, m_wait = 0, m_ok = 0;
    int       m_drop = 0;

    int iss_cmd[$];
    int iss_edge[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: a FIFO of commands, a "waiting for done" flag, and the
    // rule that a pop needs a non-empty queue, busy low and no issue last cycle.
    always @(posedge clk) begin : model
        bit pop, acc;
        int hd;
        cyc++;
        if (reset) begin
            mq.delete();
            m_cmd = '0; m_cv = 0; m_seq = 0; m_wait = 0; m_drop = 0; m_ok = 1;
        end else begin
            acc   = host_valid && (mq.size() < DEPTH);
            pop   = !m_wait && (mq.size() > 0) && !busy && !m_cv;
            m_seq = m_wait && done;
            if (m_seq) m_wait = 0;
            m_cv = pop;
            if (pop) begin
                hd    = mq.pop_front();
                m_cmd = 4'(hd);
                if (hd == 0) m_wait = 1;
            end
            if (acc) begin
                if (host_cmd < 4'd12) mq.push_back(int'(host_cmd));
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (m_ok) begin
            chk("cmd_valid",  cmd_valid,  m_cv);
            chk("cmd",        cmd,        m_cmd);
            chk("seq_done",   seq_done,   m_seq);
            chk("drop_cnt",   drop_cnt,   m_drop);
            chk("fifo_count", fifo_count, mq.size());
            chk("host_ready", host_ready, (mq.size() < DEPTH));
            if (cmd_valid === 1'b1) begin
                iss_cmd.push_back(int'(cmd));
                iss_edge.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c);
        host_valid = 1'b1;
        host_cmd   = 4'(c);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_cv(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_valid === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("wait_cv_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, pe, rel;

        // Reset values
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        chk("rst_cmd_valid",  cmd_valid,  0);
        chk("rst_cmd",        cmd,        0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_host_ready", host_ready, 1);
        chk("rst_drop_cnt",   drop_cnt,   0);
        chk("rst_seq_done",   seq_done,   0);

        // 1,4,8 back to back: first issue one edge after the write edge, then every other edge
        base = iss_cmd.size();
        pe   = cyc + 1;
        push(1); push(4); push(8);
        step(10);
        chk("t1_count", iss_cmd.size() - base, 3);
        if (iss_cmd.size() - base == 3) begin
            chk("t1_c0", iss_cmd[base],   1);
            chk("t1_c1", iss_cmd[base+1], 4);
            chk("t1_c2", iss_cmd[base+2], 8);
            chk("t1_latency", iss_edge[base] - pe, 1);
            chk("t1_gap0", iss_edge[base+1] - iss_edge[base],   2);
            chk("t1_gap1", iss_edge[base+2] - iss_edge[base+1], 2);
        end
        chk("t1_fifo_empty", fifo_count, 0);

        // 5 then 3 with busy high for 4 cycles after 5 is issued
        base = iss_cmd.size();
        push(5); push(3);
        wait_cv(10);
        step(1);
        busy = 1'b1;
        step(4);
        chk("t2_held", iss_cmd.size() - base, 1);
        busy = 1'b0;
        rel  = cyc + 1;
        step(4);
        chk("t2_count", iss_cmd.size() - base, 2);
        if (iss_cmd.size() - base == 2) begin
            chk("t2_c1", iss_cmd[base+1], 3);
            chk("t2_edge", iss_edge[base+1], rel);
        end

        // Illegal commands dropped, counter saturates
        base = iss_cmd.size();
        push(2); push(12); push(15); push(9);
        step(8);
        chk("t3_count", iss_cmd.size() - base, 2);
        if (iss_cmd.size() - base == 2) begin
            chk("t3_c0", iss_cmd[base],   2);
            chk("t3_c1", iss_cmd[base+1], 9);
        end
        chk("t3_drop2", drop_cnt, 2);
        for (int i = 0; i < 300; i++) push(12 + $urandom_range(0, 3));
        step(2);
        chk("t3_drop_sat", drop_cnt, 255);

        // Fill to full under busy, then steady-state push+pop across pointer wrap
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push($urandom_range(1, 11));
        chk("t4_full_count", fifo_count, 16);
        chk("t4_full_ready", host_ready, 0);
        push(7);
        chk("t4_rejected", fifo_count, 16);
        busy = 1'b0;
        step(1);
        chk("t4_one_pop", fifo_count, 15);
        chk("t4_ready_back", host_ready, 1);
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid === 1'b0) push($urandom_range(1, 11));
            else step(1);
        end
        chk("t4_steady", fifo_count, 15);
        step(40);
        chk("t4_drained", fifo_count, 0);

        // Write holds the queue until done
        base = iss_cmd.size();
        push(0); push(1); push(2);
        step(3);
        chk("t5_write_issued", iss_cmd.size() - base, 1);
        if (iss_cmd.size() - base == 1) chk("t5_c0", iss_cmd[base], 0);
        step(20);
        chk("t5_held", iss_cmd.size() - base, 1);
        chk("t5_queued", fifo_count, 2);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("t5_seq_done", seq_done, 1);
        step(1);
        chk("t5_resume_cv", cmd_valid, 1);
        chk("t5_resume_cmd", cmd, 1);
        chk("t5_seq_pulse", seq_done, 0);
        step(6);

        // Reset mid-burst
        busy = 1'b1;
        for (int i = 0; i < 7; i++) push($urandom_range(1, 11));
        busy = 1'b0;
        wait_cv(10);
        chk("t6_pre_count", fifo_count, 6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_cv",    cmd_valid,  0);
        chk("t6_fifo",  fifo_count, 0);
        chk("t6_ready", host_ready, 1);
        chk("t6_drop",  drop_cnt,   0);
        step(4);
        chk("t6_idle",  cmd_valid,  0);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            host_valid = 1'($urandom_range(0, 1));
            host_cmd   = ($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                     : 4'($urandom_range(0, 11));
            busy       = ($urandom_range(0, 3) == 0);
            done       = ($urandom_range(0, 7) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            step(1);
        end
        host_valid = 1'b0; busy = 1'b0; done = 1'b0; reset = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
